// File: rtl/io_cond_pkg.sv
// Shared constants and helpers for the io_conditioner input-conditioning block.
package io_cond_pkg;

  localparam int MAX_CHANNELS    = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE    = 16;

  // Width of a debounce counter that must reach debounce_cycles-1; never below 1 bit.
  function automatic int cnt_width(input int debounce_cycles);
    int w;
    w = $clog2(debounce_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : io_cond_pkg

// File: rtl/io_cond_channel.sv
// One input channel: synchroniser, debounce counter, polarity adjust and edge detector.
module io_cond_channel
  import io_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter logic INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  input  logic inv_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_next_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dout_q, rise_q, fall_q;
  logic                   dout_d, rise_d, fall_d;

  // Shift the raw pin through the synchroniser chain; nothing else samples din_i.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Debounce: accept a new level only after it persists; any reversion restarts the count.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_lvl != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync_lvl;
      else                   cnt_d    = cnt_q + 1'b1;
    end
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
    dout_d = stable_d ^ INVERT ^ inv_i;
  end

  // Register debounced level, counter and all outputs; reset drops any pending transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      dout_q   <= INVERT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign dout_o      = dout_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  // Derived from registered state only, so the top can register any_edge alongside the pulses.
  assign edge_next_o = rise_d | fall_d;

endmodule : io_cond_channel

// File: rtl/io_conditioner.sv
// Multi-channel board-input conditioner: per-channel sync/debounce/invert/edge plus any_edge.
module io_conditioner
  import io_cond_pkg::*;
#(
  parameter int                CHANNELS        = 4,
  parameter int                SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter logic [CHANNELS-1:0] INVERT_MASK   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
  input  logic [CHANNELS-1:0] inv,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_edge
);

  logic [CHANNELS-1:0] edge_next;
  logic                any_edge_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    io_cond_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (INVERT_MASK[i])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_i      (din[i]),
      .inv_i      (inv[i]),
      .dout_o     (dout[i]),
      .rise_o     (rise[i]),
      .fall_o     (fall[i]),
      .edge_next_o(edge_next[i])
    );
  end

  // Register the OR of next-cycle edges so any_edge lines up with the rise/fall pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_edge_q <= 1'b0;
    else        any_edge_q <= |edge_next;
  end

  assign any_edge = any_edge_q;

endmodule : io_conditioner

// File: tb/tb_io_conditioner.sv
// Scoreboard bench for io_conditioner: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INVERT_MASK=0010.
module tb_io_conditioner;

  localparam int         CH   = 4;
  localparam int         SS   = 2;
  localparam int         DB   = 4;
  localparam logic [3:0] MASK = 4'b0010;
  localparam int         LAT  = SS + DB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] din, inv, dout, rise, fall;
  logic          any_edge;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] dout;
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;

  io_conditioner #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .INVERT_MASK    (MASK)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .inv     (inv),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall),
    .any_edge(any_edge)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Inputs change 1 time unit after a falling edge, well away from the active edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Expected pulse lands LAT edges after a din change driven at the current cycle.
  task automatic expect_ev(input logic [3:0] r, input logic [3:0] f, input logic [3:0] d);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.rise = r;
    e.fall = f;
    e.dout = d;
    exp_q.push_back(e);
  endtask

  // Monitor: any pulse on the outputs is an event; pop and compare against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if ((rise | fall) != 4'b0 || any_edge) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {20'b0, rise, fall, 3'b0, any_edge}, 32'h0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_rise", rise, e.rise);
          check("event_fall", fall, e.fall);
          check("event_any_edge", any_edge, 1'b1);
          check("event_dout", dout, e.dout);
        end
      end
    end
  end

  initial begin
    // Reset with inputs high: outputs show only the compile-time mask.
    rst_n = 1'b0;
    din   = 4'b1111;
    inv   = 4'b0000;
    step(3);
    check("reset_dout", dout, MASK);
    check("reset_rise", rise, 4'b0);
    check("reset_fall", fall, 4'b0);
    check("reset_any_edge", any_edge, 1'b0);
    din   = 4'b0000;
    rst_n = 1'b1;
    step(20);
    check("post_reset_dout", dout, MASK);

    // Clean rising then falling edge on channel 0.
    din[0] = 1'b1;
    expect_ev(4'b0001, 4'b0000, 4'b0011);
    step(LAT - 1);
    check("clean_rise_not_early", dout, 4'b0010);
    step(5);
    check("clean_rise_level", dout, 4'b0011);
    din[0] = 1'b0;
    expect_ev(4'b0000, 4'b0001, 4'b0010);
    step(10);
    check("clean_fall_level", dout, 4'b0010);

    // Glitch of DB-1 cycles on channel 2 is rejected; DB cycles is accepted.
    din[2] = 1'b1;
    step(DB - 1);
    din[2] = 1'b0;
    step(10);
    check("glitch_rejected", dout, 4'b0010);
    din[2] = 1'b1;
    expect_ev(4'b0100, 4'b0000, 4'b0110);
    step(10);
    check("glitch_accepted", dout, 4'b0110);

    // Compile-time inverted channel 1 still reports the pre-inversion edge.
    din[1] = 1'b1;
    expect_ev(4'b0010, 4'b0000, 4'b0100);
    step(10);
    check("inverted_ch1", dout, 4'b0100);

    // Run-time inversion of channel 3: registered, no pulses.
    inv = 4'b1000;
    check("inv_not_combinational", dout, 4'b0100);
    step(1);
    check("inv_one_edge_later", dout, 4'b1100);
    inv = 4'b0000;
    step(2);
    check("inv_cleared", dout, 4'b0100);

    // Bring channels 1 and 2 low together, then all four high together.
    din = 4'b0000;
    expect_ev(4'b0000, 4'b0110, 4'b0010);
    step(10);
    din = 4'b1111;
    expect_ev(4'b1111, 4'b0000, 4'b1101);
    step(10);
    check("all_high_level", dout, 4'b1101);

    // Drop all inputs, then reset two edges into the debounce count.
    din = 4'b0000;
    step(SS + 2);
    rst_n = 1'b0;
    #1;
    check("midcount_reset_dout", dout, MASK);
    check("midcount_reset_fall", fall, 4'b0);
    step(2);
    rst_n = 1'b1;
    step(20);
    check("after_midcount_reset", dout, MASK);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_io_conditioner

// File: doc/io_conditioner.md
Name: io_conditioner

Overview:
Parametrised multi-channel successor to the single-bit inverter used on the EBAZ4205 LED/button path. Each channel of an asynchronous board-level input is:
- synchronised,
- debounced,
- optionally inverted (compile-time mask XOR run-time mask),
- edge-detected into one-cycle rise/fall pulses.

It sits between board pins (buttons, jumpers, PHY status lines) and PL logic such as the LED blinker and Ethernet status handling.

Parameters:
CHANNELS, 4, number of independent input channels (1..32).
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (2..4).
DEBOUNCE_CYCLES, 16, consecutive clk cycles a new level must persist before it is accepted (1..2^20).
INVERT_MASK, {CHANNELS{1'b0}}, per-channel compile-time polarity; bit=1 inverts that channel's dout.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset; deassertion synchronised externally.
din  input  CHANNELS  raw asynchronous inputs.
inv  input  CHANNELS  run-time polarity mask, synchronous to clk, XORed with INVERT_MASK.
dout  output  CHANNELS  debounced, polarity-adjusted level, registered.
rise  output  CHANNELS  one-cycle pulse on debounced 0->1 (pre-inversion level).
fall  output  CHANNELS  one-cycle pulse on debounced 1->0 (pre-inversion level).
any_edge  output  1  registered OR of all rise|fall bits, same cycle as the pulses.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - synchroniser flops, stable level and debounce counters = 0.
  - rise = fall = 0, any_edge = 0.
  - dout = INVERT_MASK.
- Synchroniser: din[i] passes through SYNC_STAGES flops; the last stage is sync[i]. No other logic touches din.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - if sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - else if sync != stable: cnt <= cnt+1.
  - else: cnt <= 0. Any reversion restarts the count; no partial credit is kept.
- Latency: a din change that meets setup before edge 1 updates stable/dout/rise/fall on edge SYNC_STAGES+DEBOUNCE_CYCLES. Pulses of fewer than DEBOUNCE_CYCLES synced cycles are rejected.
- dout[i] <= stable_next[i] ^ INVERT_MASK[i] ^ inv[i]. An inv change alone shows on dout one edge later and produces no rise/fall.
- rise[i] <= stable_next & ~stable; fall[i] <= ~stable_next & stable. Each is high for exactly one cycle; rise and fall are never high together on one channel.
- any_edge <= |(rise_next | fall_next).
- Channels are fully independent; simultaneous events on several channels give simultaneous pulses.
- DEBOUNCE_CYCLES=1: stable follows sync with one edge of delay; the counter is still instantiated (width 1).
- Reset mid-count: the count and any pending transition are discarded; no pulse is emitted on reset release.
- No combinational path from any input to any output.

Decomposition:
- Package io_cond_pkg:
  - function cnt_width(DEBOUNCE_CYCLES).
  - default constants DEF_SYNC_STAGES=2 and DEF_DEBOUNCE=16.
  - localparam MAX_CHANNELS=32.
- Sub-module io_cond_channel: one synchroniser + debounce counter + edge detector, parametrised by SYNC_STAGES, DEBOUNCE_CYCLES and INVERT (1 bit).
- The top generates CHANNELS instances and registers any_edge.

Test Plan:
CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INVERT_MASK=4'b0010, inv=0 unless stated.
- Reset: hold rst_n=0, din=4'b1111 -> dout=4'b0010, rise=fall=0, any_edge=0; release, keep din=0 -> outputs unchanged for 20 cycles.
- Clean edge: din[0] 0->1 before edge 1, held -> rise[0]=1 and any_edge=1 for exactly the cycle after edge 6; dout[0]=1 from edge 6. din[0] 1->0 -> fall[0] pulse after 6 edges, dout[0]=0.
- Glitch reject: din[2]=1 for 3 cycles then 0 -> dout[2], rise[2], any_edge stay 0. Then 4 cycles high -> accepted, rise[2] pulses.
- Inversion: din[1]=1 held -> dout[1]=0 and rise[1] pulses. Set inv=4'b1000 with din[3]=0 -> dout[3]=1 one edge later, no rise/fall on channel 3.
- Simultaneous + reset mid-count: din=4'b1111 together -> rise=4'b1111 in one cycle. Then din=0 and assert rst_n after 2 edges of debounce -> no fall pulses; dout=4'b0010 immediately.
